div_unit: RTL and testbench

- Multi-cycle responder for the RV32M division group (OPDIV, OPDIVU, OPREM, OPREMU), using the shared operation codes from the common parameter file.
- The CPU datapath is the initiator: it issues a one-cycle start with operands, stalls while busy, and takes the result on the ready pulse.
- Radix-2 restoring divider, one quotient bit per cycle.
- Replaces the single-cycle combinational divide path for timing-closed builds.

---
 rtl/div_unit_if.sv | 38 +++
 rtl/div_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_div_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the CPU datapath (master)
// and the multi-cycle divider (slave). Clock and reset are not part of the
// bundle; they are plain ports on the divider.
interface div_unit_if #(
   parameter int WIDTH = 32
);

   logic             iStart;
   logic [4:0]       iControl;
   logic [WIDTH-1:0] iA;
   logic [WIDTH-1:0] iB;
   logic             oBusy;
   logic             oReady;
   logic [WIDTH-1:0] oResult;

   // CPU side: issues the request and collects the result
   modport master (
      output iStart,
      output iControl,
      output iA,
      output iB,
      input  oBusy,
      input  oReady,
      input  oResult
   );

   // Divider side: accepts the request and returns the result
   modport slave (
      input  iStart,
      input  iControl,
      input  iA,
      input  iB,
      output oBusy,
      output oReady,
      output oResult
   );

endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the RV32M division
// group (DIV, DIVU, REM, REMU). One quotient bit is produced per cycle.
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, a request whose divisor magnitude exceeds the dividend
//   magnitude skips the iteration and completes with latency 1
//   (quotient 0, remainder = dividend). Results are identical either way;
//   only latency changes.
//
// Timeline for a normal request accepted at edge 0:
//   edges 1..WIDTH  one restoring step each (CALC)
//   cycle WIDTH     DONE: sign correction and result selection
//   edge WIDTH+1    oResult/oReady registered, FSM back in IDLE
// Special cases go from IDLE straight to DONE, giving oReady at edge 1.
//
// The operation codes are parameters so the integrator can bind them to the
// values of the shared CPU parameter file.
module div_unit #(
   parameter int         WIDTH  = 32,
   parameter logic [4:0] OPDIV  = 5'b10100,
   parameter logic [4:0] OPDIVU = 5'b10101,
   parameter logic [4:0] OPREM  = 5'b10110,
   parameter logic [4:0] OPREMU = 5'b10111
) (
   input logic        iCLK,
   input logic        iRST,
   div_unit_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   // Operation context captured at accept time
   logic [4:0]       op_q;
   logic             neg_quot_q;
   logic             neg_rem_q;
   logic             special_q;

   // Iteration registers. dvd starts as the dividend magnitude and, as it
   // shifts left, collects quotient bits in its LSB; after WIDTH steps it
   // holds the quotient magnitude. For special cases it carries the final
   // result directly so no extra register is needed.
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic [CW-1:0]    count;

   // Output registers
   logic             ready_q;
   logic [WIDTH-1:0] result_q;

   // Request decode (valid only while IDLE with a start present)
   logic             in_signed;
   logic             in_div;
   logic             in_valid;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic             div_by_zero;
   logic             overflow;
   logic             early_out;
   logic             special;
   logic [WIDTH-1:0] special_result;

   // One restoring step
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   diff;
   logic             take;

   // Final sign correction
   logic             op_is_div;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] final_result;

   // Classify the incoming request and derive operand magnitudes. Signed ops
   // use magnitudes; the most negative value maps onto itself, which is the
   // correct unsigned magnitude.
   always_comb begin
      in_signed = (bus.iControl == OPDIV) || (bus.iControl == OPREM);
      in_div    = (bus.iControl == OPDIV) || (bus.iControl == OPDIVU);
      in_valid  = in_signed || (bus.iControl == OPDIVU) || (bus.iControl == OPREMU);
      sign_a    = in_signed && bus.iA[WIDTH-1];
      sign_b    = in_signed && bus.iB[WIDTH-1];
      mag_a     = sign_a ? -bus.iA : bus.iA;
      mag_b     = sign_b ? -bus.iB : bus.iB;
      div_by_zero = (bus.iB == '0);
      overflow    = in_signed && (bus.iA == MOST_NEG) && (bus.iB == ALL_ONES);
   end

`ifdef DIV_EARLY_OUT_EN
   // A divisor larger than the dividend always yields quotient 0 and the
   // dividend as remainder, so the iteration can be skipped.
   assign early_out = (mag_b > mag_a);
`else
   assign early_out = 1'b0;
`endif

   // Decide whether the request bypasses the iteration and, if so, what the
   // finished result is. Priority: unknown op, divide by zero, overflow,
   // early out.
   always_comb begin
      special        = !in_valid || div_by_zero || overflow || early_out;
      special_result = '0;
      if (!in_valid) begin
         special_result = '0;
      end else if (div_by_zero) begin
         special_result = in_div ? ALL_ONES : bus.iA;
      end else if (overflow) begin
         special_result = in_div ? MOST_NEG : '0;
      end else if (early_out) begin
         special_result = in_div ? '0 : bus.iA;
      end
   end

   // One restoring step: shift the next dividend bit into the partial
   // remainder and subtract the divisor if it fits. The subtraction is done
   // at WIDTH+1 bits so its top bit is the borrow, i.e. "did not fit".
   always_comb begin
      rem_shift = {rem, dvd[WIDTH-1]};
      diff      = rem_shift - {1'b0, dvs};
      take      = ~diff[WIDTH];
   end

   // Apply the sign rules to the raw quotient/remainder and pick the result
   // for the latched operation. This happens in the DONE cycle so the
   // negation is kept off the iteration path.
   always_comb begin
      op_is_div    = (op_q == OPDIV) || (op_q == OPDIVU);
      quot_fix     = neg_quot_q ? -dvd : dvd;
      rem_fix      = neg_rem_q  ? -rem : rem;
      final_result = special_q ? dvd : (op_is_div ? quot_fix : rem_fix);
   end

   // State register with synchronous reset
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: starts are only honoured in IDLE, special cases skip
   // CALC, and DONE always lasts a single cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.iStart) begin
               state_next = special ? DONE : CALC;
            end
         end
         CALC: begin
            if (count == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath and output registers. A reset in the middle of an operation
   // clears everything, so no late ready pulse can escape.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         op_q       <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         special_q  <= 1'b0;
         dvd        <= '0;
         dvs        <= '0;
         rem        <= '0;
         count      <= '0;
         ready_q    <= 1'b0;
         result_q   <= '0;
      end else begin
         ready_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.iStart) begin
                  op_q       <= bus.iControl;
                  neg_quot_q <= sign_a ^ sign_b;
                  neg_rem_q  <= sign_a;
                  special_q  <= special;
                  dvd        <= special ? special_result : mag_a;
                  dvs        <= mag_b;
                  rem        <= '0;
                  count      <= LAST_COUNT;
               end
            end
            CALC: begin
               dvd <= {dvd[WIDTH-2:0], take};
               rem <= take ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
               if (count != '0) begin
                  count <= count - CW'(1);
               end
            end
            DONE: begin
               ready_q  <= 1'b1;
               result_q <= final_result;
            end
            default: begin
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.oBusy   = (state != IDLE);
   assign bus.oReady  = ready_q;
   assign bus.oResult = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// Expected values are hand-computed; latency is counted in rising edges from
// the edge that accepts the start. Honours DIV_EARLY_OUT_EN for the one case
// whose latency depends on it.
module tb_div_unit;

   localparam logic [4:0] OPDIV  = 5'b10100;
   localparam logic [4:0] OPDIVU = 5'b10101;
   localparam logic [4:0] OPREM  = 5'b10110;
   localparam logic [4:0] OPREMU = 5'b10111;
   localparam logic [4:0] OPBAD  = 5'b00000;

`ifdef DIV_EARLY_OUT_EN
   localparam int EarlyLat = 1;
`else
   localparam int EarlyLat = 33;
`endif

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   div_unit_if #(.WIDTH(32)) bus ();

   div_unit #(
      .WIDTH  (32),
      .OPDIV  (OPDIV),
      .OPDIVU (OPDIVU),
      .OPREM  (OPREM),
      .OPREMU (OPREMU)
   ) dut (
      .iCLK (clock),
      .iRST (reset),
      .bus  (bus)
   );

   // Free-running clock, period 10
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports failures
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Present a request for one cycle; returns just after the accepting edge
   task automatic applyStimulus(input logic [4:0] ctrl, input logic [31:0] a,
                                input logic [31:0] b);
      @(negedge clock);
      bus.iStart   = 1'b1;
      bus.iControl = ctrl;
      bus.iA       = a;
      bus.iB       = b;
      @(posedge clock);
      #1;
      bus.iStart = 1'b0;
   endtask

   // Wait (bounded) for the ready pulse; lat = edges since accept, 0 on timeout
   task automatic waitReady(input int already, output int lat);
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clock);
         #1;
         if (bus.oReady) begin
            lat = already + i;
            break;
         end
      end
   endtask

   // Full transaction with result, latency, busy and pulse-width checks
   task automatic runOp(input string tag, input logic [4:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expResult, input int expLat);
      int lat;
      applyStimulus(ctrl, a, b);
      checkOutput({tag, " busy"}, 32'(bus.oBusy), 32'd1);
      waitReady(0, lat);
      checkOutput({tag, " result"}, bus.oResult, expResult);
      checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, " busy_clear"}, 32'(bus.oBusy), 32'd0);
      @(posedge clock);
      #1;
      checkOutput({tag, " pulse_end"}, 32'(bus.oReady), 32'd0);
      checkOutput({tag, " hold"}, bus.oResult, expResult);
   endtask

   // Directed sequence
   initial begin
      int lat;
      int latePulses;
      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      bus.iStart   = 1'b0;
      bus.iControl = '0;
      bus.iA       = '0;
      bus.iB       = '0;

      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset busy", 32'(bus.oBusy), 32'd0);
      checkOutput("reset ready", 32'(bus.oReady), 32'd0);
      checkOutput("reset result", bus.oResult, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      $display("[TB] basic unsigned and signed division");
      runOp("divu 100/7", OPDIVU, 32'd100, 32'd7, 32'd14, 33);
      runOp("remu 100/7", OPREMU, 32'd100, 32'd7, 32'd2, 33);
      runOp("rem -7/2", OPREM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      runOp("div -7/2", OPDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      runOp("div 20/-3", OPDIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
      runOp("rem 20/-3", OPREM, 32'd20, 32'hFFFF_FFFD, 32'd2, 33);
      runOp("rem -20/-3", OPREM, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 33);
      runOp("divu big", OPDIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);

      $display("[TB] special cases");
      runOp("div 55/0", OPDIV, 32'd55, 32'd0, 32'hFFFF_FFFF, 1);
      runOp("remu 55/0", OPREMU, 32'd55, 32'd0, 32'd55, 1);
      runOp("rem -5/0", OPREM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
      runOp("div ovf", OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      runOp("rem ovf", OPREM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      runOp("bad op", OPBAD, 32'd100, 32'd7, 32'd0, 1);

      $display("[TB] divisor larger than dividend");
      runOp("divu 3/10", OPDIVU, 32'd3, 32'd10, 32'd0, EarlyLat);
      runOp("remu 3/10", OPREMU, 32'd3, 32'd10, 32'd3, EarlyLat);
      runOp("rem 3/-10", OPREM, 32'd3, 32'hFFFF_FFF6, 32'd3, EarlyLat);

      $display("[TB] start ignored while busy");
      applyStimulus(OPDIVU, 32'd100, 32'd7);
      repeat (4) @(posedge clock);
      @(negedge clock);
      bus.iStart   = 1'b1;
      bus.iControl = OPREMU;
      bus.iA       = 32'd1000;
      bus.iB       = 32'd3;
      @(posedge clock);
      #1;
      bus.iStart = 1'b0;
      checkOutput("ignore busy", 32'(bus.oBusy), 32'd1);
      waitReady(5, lat);
      checkOutput("ignore result", bus.oResult, 32'd14);
      checkOutput("ignore latency", 32'(lat), 32'd33);
      @(posedge clock);
      #1;
      checkOutput("ignore no second", 32'(bus.oBusy), 32'd0);

      $display("[TB] reset during CALC");
      applyStimulus(OPDIVU, 32'd1000, 32'd9);
      repeat (10) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("abort busy", 32'(bus.oBusy), 32'd0);
      checkOutput("abort ready", 32'(bus.oReady), 32'd0);
      checkOutput("abort result", bus.oResult, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      latePulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (bus.oReady) latePulses++;
      end
      checkOutput("abort late pulse", 32'(latePulses), 32'd0);

      $display("[TB] recovery after reset");
      runOp("divu after reset", OPDIVU, 32'd1000, 32'd9, 32'd111, 33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
